univ_shift_reg: RTL
===================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised universal shift register, successor to the 3-stage JK-flip-flop shifter.
//  Supports hold, shift-left, shift-right and parallel load at any width.
//  Adds a burst engine that shifts N places from a single START, with BUSY/DONE handshake.
//  Sits between switch/serial inputs and LED/downstream datapath registers.
// PARAMETERS
//  WIDTH  8                       number of register stages (>=2)
//  CW     $clog2(WIDTH+1)         width of burst COUNT (derived, do not override)
// PORTS
//  CLK    in   1      single clock, rising edge
//  RESET  in   1      asynchronous, active-low reset
//  EN     in   1      clock enable; 0 freezes Q, FSM, counter
//  MODE   in   2      00 hold, 01 shift-right, 10 shift-left, 11 parallel load
//  SER_R  in   1      serial in at MSB for shift-right
//  SER_L  in   1      serial in at LSB for shift-left
//  D      in   WIDTH  parallel load data
//  START  in   1      begin burst of COUNT shifts in direction MODE
//  COUNT  in   CW     burst length
//  Q      out  WIDTH  register contents
//  SO_R   out  1      Q[0], combinational
//  SO_L   out  1      Q[WIDTH-1], combinational
//  BUSY   out  1      burst in progress
//  DONE   out  1      one-cycle pulse at burst completion
//  ROT    in   1      only with USR_ROTATE_EN (see CONFIGURATION)
// BEHAVIOUR
//  - RESET low (async): Q=0, state IDLE, BUSY=0, DONE=0, remaining count=0. Aborts any burst.
//  - Manual op (IDLE, EN=1, START=0), per edge:
//    right: Q<={SER_R,Q[W-1:1]}; left: Q<={Q[W-2:0],SER_L}; load: Q<=D; hold: Q unchanged.
//  - FSM states: IDLE -> SHIFT -> FIN -> IDLE.
//  - IDLE, EN=1, START=1: latch direction from MODE and cnt=min(COUNT,WIDTH).
//    No shift occurs on the START edge.
//    cnt==0, or MODE is hold/load: go to FIN (no shift, no load); else go to SHIFT.
//  - SHIFT: BUSY=1; each EN=1 edge does one shift in the latched direction and cnt--.
//    Serial inputs are sampled live each shift. The edge taking cnt to 0 goes to FIN.
//  - FIN: DONE=1 for exactly one cycle; BUSY=0; next edge with EN=1 goes to IDLE.
//  - Latency: N-shift burst -> DONE high N+1 edges after START edge.
//  - While BUSY or in FIN: MODE, D and START are ignored. START is not queued.
//  - EN=0 in any state: everything frozen, DONE stays high if in FIN.
//  - COUNT>WIDTH saturates to WIDTH (register fully replaced by serial data).
//  - SO_R/SO_L are valid during bursts (daisy-chain use).
// CONFIGURATION
//  USR_ROTATE_EN defined: ROT port exists. When ROT=1 (manual or sampled at START),
//    shift-right feeds Q[0] into MSB and shift-left feeds Q[W-1] into LSB.
//    SER_R/SER_L are ignored; WIDTH-shift burst returns Q to its start value.
//  USR_ROTATE_EN undefined: no ROT port; serial inputs always used; no rotate logic.
// STRUCTURE
//  - Package usr_pkg: typedef enum usr_mode_t {HOLD,SHR,SHL,LOAD};
//    typedef enum usr_state_t {IDLE,SHIFT,FIN}.
//  - Sub-module usr_stage: one bit cell, 4:1 mux (hold/left-nbr/right-nbr/D) + async-clear flop.
//    Instantiated WIDTH times via generate.
//  - Top holds FSM, counter, rotate muxing.
// TESTING (WIDTH=8)
//  - Reset mid-burst: Q=8'hA5, START SHL COUNT=5, RESET low after 2 edges
//    -> Q=0, BUSY=0, DONE=0 immediately.
//  - Manual: load D=8'h81, then SHR with SER_R=1 for 3 edges -> Q=8'hF0, SO_R=0.
//  - Burst: Q=8'h01, START SHL COUNT=3, SER_L=0 -> BUSY high 3 cycles, Q=8'h08,
//    DONE 1-cycle pulse at edge 4; START during BUSY ignored.
//  - Edge counts: COUNT=0 -> DONE next cycle, Q unchanged; COUNT=15 -> exactly 8 shifts.
//    EN=0 for 2 cycles mid-burst stretches BUSY by 2.
//  - USR_ROTATE_EN, ROT=1: Q=8'h96, START SHR COUNT=8 -> Q=8'h96 at DONE;
//    COUNT=1 -> Q=8'h4B.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// Shared mode and state types for the universal shift register (package usr_pkg).
package usr_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } usr_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        FIN   = 2'b10
    } usr_state_t;

    function automatic logic is_shift(input usr_mode_t m);
        return (m == SHR) || (m == SHL);
    endfunction

endpackage

// File: rtl/univ_shift_reg_stage.sv
// One register bit: 4:1 select between hold, upper neighbour, lower neighbour and load data.
module usr_stage
    import usr_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  usr_mode_t sel,
    input  logic      from_hi,
    input  logic      from_lo,
    input  logic      d,
    output logic      q
);

    logic q_d, q_q;

    always_comb begin
        q_d = q_q;
        case (sel)
            HOLD:    q_d = q_q;
            SHR:     q_d = from_hi;
            SHL:     q_d = from_lo;
            LOAD:    q_d = d;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= 1'b0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with burst engine (START/BUSY/DONE).
// Define USR_ROTATE_EN to add the ROT port and rotate-through feedback.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             SER_R,
    input  logic             SER_L,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic [CW-1:0]    COUNT,
    output logic [WIDTH-1:0] Q,
    output logic             SO_R,
    output logic             SO_L,
    output logic             BUSY,
    output logic             DONE
`ifdef USR_ROTATE_EN
    ,
    input  logic             ROT
`endif
);

    usr_state_t    state_d, state_q;
    usr_mode_t     dir_d, dir_q;
    usr_mode_t     mode_in, op;
    logic [CW-1:0] cnt_d, cnt_q, cnt_sat;
    logic          busy_d, busy_q, done_d, done_q;
    logic          msb_in, lsb_in;
    logic [WIDTH-1:0] q_w;

    assign mode_in = usr_mode_t'(MODE);
    assign cnt_sat = (COUNT > CW'(WIDTH)) ? CW'(WIDTH) : COUNT;

`ifdef USR_ROTATE_EN
    logic rot_d, rot_q, rot_sel;

    // A burst uses the ROT value captured at START; manual ops use it live.
    assign rot_sel = (state_q == SHIFT) ? rot_q : ROT;
    assign msb_in  = rot_sel ? q_w[0] : SER_R;
    assign lsb_in  = rot_sel ? q_w[WIDTH-1] : SER_L;

    always_comb begin
        rot_d = rot_q;
        if (EN && (state_q == IDLE) && START) rot_d = ROT;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) rot_q <= 1'b0;
        else        rot_q <= rot_d;
    end
`else
    assign msb_in = SER_R;
    assign lsb_in = SER_L;
`endif

    // The START edge itself never moves data; only IDLE manual ops and SHIFT do.
    always_comb begin
        op = HOLD;
        if (EN) begin
            case (state_q)
                IDLE:    op = START ? HOLD : mode_in;
                SHIFT:   op = dir_q;
                default: op = HOLD;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (EN) begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        dir_d = mode_in;
                        if ((cnt_sat == '0) || !is_shift(mode_in)) begin
                            state_d = FIN;
                            cnt_d   = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = SHIFT;
                            cnt_d   = cnt_sat;
                            busy_d  = 1'b1;
                            done_d  = 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                FIN: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            dir_q   <= HOLD;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_stage
        logic from_hi, from_lo;
        if (i == WIDTH - 1) begin : g_top
            assign from_hi = msb_in;
        end else begin : g_mid_hi
            assign from_hi = q_w[i+1];
        end
        if (i == 0) begin : g_bot
            assign from_lo = lsb_in;
        end else begin : g_mid_lo
            assign from_lo = q_w[i-1];
        end
        usr_stage u_stage (
            .clk     (CLK),
            .rst_n   (RESET),
            .sel     (op),
            .from_hi (from_hi),
            .from_lo (from_lo),
            .d       (D[i]),
            .q       (q_w[i])
        );
    end

    assign Q    = q_w;
    assign SO_R = q_w[0];
    assign SO_L = q_w[WIDTH-1];
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule
